// File: rtl/cmd_frame_pkg.sv
// Shared definitions for the 9-byte pulse-command frame.
// Used by the frame encoder (cmd_frame_tx) and by the command parser, so the
// byte order and header value stay identical on both sides of the link.
package cmd_frame_pkg;

  localparam logic [7:0] FRAME_HEAD = 8'h07;
  localparam int         FRAME_LEN  = 9;

  localparam logic [3:0] IDX_HEAD  = 4'd0;
  localparam logic [3:0] IDX_SEL1  = 4'd1;
  localparam logic [3:0] IDX_SEL2  = 4'd2;
  localparam logic [3:0] IDX_W1_H  = 4'd3;
  localparam logic [3:0] IDX_W1_L  = 4'd4;
  localparam logic [3:0] IDX_W2_H  = 4'd5;
  localparam logic [3:0] IDX_W2_L  = 4'd6;
  localparam logic [3:0] IDX_GAP_H = 4'd7;
  localparam logic [3:0] IDX_GAP_L = 4'(FRAME_LEN - 1);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_SEND = 3'd2;
  localparam logic [2:0] ST_WAIT = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  typedef struct packed {
    logic [1:0]  sel;
    logic [15:0] width1;
    logic [15:0] width2;
    logic [15:0] gap;
  } frame_cfg_t;

  // Nine-way byte select; values go out raw, no clamping.
  function automatic logic [7:0] frame_byte(input frame_cfg_t cfg,
                                            input logic [3:0] idx,
                                            input logic [7:0] head);
    case (idx)
      IDX_HEAD:  frame_byte = head;
      IDX_SEL1:  frame_byte = {7'b0, cfg.sel[0]};
      IDX_SEL2:  frame_byte = {7'b0, cfg.sel[1]};
      IDX_W1_H:  frame_byte = cfg.width1[15:8];
      IDX_W1_L:  frame_byte = cfg.width1[7:0];
      IDX_W2_H:  frame_byte = cfg.width2[15:8];
      IDX_W2_L:  frame_byte = cfg.width2[7:0];
      IDX_GAP_H: frame_byte = cfg.gap[15:8];
      IDX_GAP_L: frame_byte = cfg.gap[7:0];
      default:   frame_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/byte_gap_timer.sv
// Inter-byte gap timer for cmd_frame_tx.
// Counts run cycles from a cleared state and flags the BYTE_GAP-th one.
// Ports:
//   sys_clk  in  system clock
//   sys_rst  in  synchronous reset, active-high
//   clear    in  zero the counter (issued in the byte strobe cycle)
//   run      in  count while high
//   expire   out high during the last run cycle of the gap
module byte_gap_timer #(
  parameter int BYTE_GAP = 57288
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int CNT_W = (BYTE_GAP > 1) ? $clog2(BYTE_GAP) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(BYTE_GAP - 1);

  logic [CNT_W-1:0] gap_cnt;

  assign expire = run && (gap_cnt == TERM);

  // Holds at the terminal value; the next strobe clears it.
  always_ff @(posedge sys_clk) begin
    if (sys_rst || clear) begin
      gap_cnt <= '0;
    end else if (run && !expire) begin
      gap_cnt <= gap_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cmd_frame_tx.sv
// Pulse-command frame encoder. On start, snapshots channel enables, both
// pulse widths and the gap, then streams the 9-byte frame into uart_tx,
// one pi_flag strobe per byte, spaced one character time plus guard bits.
// Ports:
//   sys_clk, sys_rst   clock, synchronous active-high reset
//   start              one-cycle request to send a frame (ignored while busy)
//   pulse_select[1:0]  ch1/ch2 enables
//   pulse_width1/2     channel pulse widths, 10 ns units
//   pulse_gap          inter-pulse gap, 10 ns units
//   pi_data, pi_flag   byte and byte-valid strobe to uart_tx
//   busy               high from the accepted start until done
//   done               one-cycle pulse after the last byte's gap
//
// state   | meaning
// IDLE    | waiting for start, busy low
// LOAD    | config snapshot valid, header staged on pi_data
// SEND    | pi_flag high for byte idx, gap timer cleared
// WAIT    | gap running; advance idx or finish after the last byte
// DONE    | done pulse, then back to IDLE
module cmd_frame_tx #(
  parameter int         UART_BPS   = 9600,
  parameter int         CLK_FREQ   = 50_000_000,
  parameter logic [7:0] FRAME_HEAD = 8'h07,
  parameter int         GUARD_BITS = 1
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        start,
  input  logic [1:0]  pulse_select,
  input  logic [15:0] pulse_width1,
  input  logic [15:0] pulse_width2,
  input  logic [15:0] pulse_gap,
  output logic [7:0]  pi_data,
  output logic        pi_flag,
  output logic        busy,
  output logic        done
);

  import cmd_frame_pkg::*;

  localparam int BYTE_GAP = (CLK_FREQ / UART_BPS) * (10 + GUARD_BITS);

  logic [2:0]  state;
  logic [3:0]  idx;
  frame_cfg_t  cfg;
  logic        gap_expire;

  assign pi_flag = (state == ST_SEND);
  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE);

  byte_gap_timer #(
    .BYTE_GAP (BYTE_GAP)
  ) u_gap_timer (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .clear   (state == ST_SEND),
    .run     (state == ST_WAIT),
    .expire  (gap_expire)
  );

  // The snapshot is taken on the edge that accepts start, so inputs that
  // move during LOAD already miss the frame in flight. pi_data is loaded
  // on the edge into SEND and held through WAIT.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state   <= ST_IDLE;
      idx     <= IDX_HEAD;
      cfg     <= '0;
      pi_data <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            cfg.sel    <= pulse_select;
            cfg.width1 <= pulse_width1;
            cfg.width2 <= pulse_width2;
            cfg.gap    <= pulse_gap;
            state      <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          idx     <= IDX_HEAD;
          pi_data <= frame_byte(cfg, IDX_HEAD, FRAME_HEAD);
          state   <= ST_SEND;
        end
        ST_SEND: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (gap_expire) begin
            if (idx == IDX_GAP_L) begin
              idx   <= IDX_HEAD;
              state <= ST_DONE;
            end else begin
              idx     <= idx + 4'd1;
              pi_data <= frame_byte(cfg, idx + 4'd1, FRAME_HEAD);
              state   <= ST_SEND;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_frame_tx.sv
// Bench for cmd_frame_tx with a short byte gap (10 clocks/bit, 11 bit-times).
module tb_cmd_frame_tx;

  localparam int CLK_FREQ   = 50_000_000;
  localparam int UART_BPS   = 5_000_000;
  localparam int GUARD_BITS = 1;
  localparam int G      = (CLK_FREQ / UART_BPS) * (10 + GUARD_BITS);
  localparam int DONE_J = 1 + 9 * (G + 1);

  logic        sys_clk;
  logic        sys_rst;
  logic        start;
  logic [1:0]  pulse_select;
  logic [15:0] pulse_width1;
  logic [15:0] pulse_width2;
  logic [15:0] pulse_gap;
  logic [7:0]  pi_data;
  logic        pi_flag;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  cmd_frame_tx #(
    .UART_BPS   (UART_BPS),
    .CLK_FREQ   (CLK_FREQ),
    .FRAME_HEAD (8'h07),
    .GUARD_BITS (GUARD_BITS)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .start        (start),
    .pulse_select (pulse_select),
    .pulse_width1 (pulse_width1),
    .pulse_width2 (pulse_width2),
    .pulse_gap    (pulse_gap),
    .pi_data      (pi_data),
    .pi_flag      (pi_flag),
    .busy         (busy),
    .done         (done)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // ---------------- reference model (timeline from the accepting edge) ---
  int         edge_n  = 0;
  bit         m_valid = 0;
  bit         m_active = 0;
  int         m_start = 0;
  logic [7:0] m_bytes [9];
  logic [7:0] m_data = 8'h00;
  logic       m_busy = 1'b0, m_done = 1'b0, m_flag = 1'b0;

  always @(posedge sys_clk) begin
    int j;
    int k;
    edge_n++;
    if (sys_rst === 1'b1) begin
      m_active = 0;
      m_data   = 8'h00;
      m_valid  = 1;
    end else if (start === 1'b1 && (!m_active || (edge_n - 1 - m_start) > DONE_J)) begin
      m_active   = 1;
      m_start    = edge_n;
      m_bytes[0] = 8'h07;
      m_bytes[1] = {7'b0, pulse_select[0]};
      m_bytes[2] = {7'b0, pulse_select[1]};
      m_bytes[3] = pulse_width1 >> 8;
      m_bytes[4] = pulse_width1 & 16'hFF;
      m_bytes[5] = pulse_width2 >> 8;
      m_bytes[6] = pulse_width2 & 16'hFF;
      m_bytes[7] = pulse_gap >> 8;
      m_bytes[8] = pulse_gap & 16'hFF;
    end
    m_busy = 1'b0;
    m_done = 1'b0;
    m_flag = 1'b0;
    if (m_active) begin
      j = edge_n - m_start;
      m_busy = (j <= DONE_J);
      m_done = (j == DONE_J);
      if (j >= 1 && (j - 1) % (G + 1) == 0) begin
        k = (j - 1) / (G + 1);
        if (k < 9) begin
          m_flag = 1'b1;
          m_data = m_bytes[k];
        end
      end
    end
  end

  // ---------------- per-cycle compare + capture ----------------
  logic [7:0] cap_q [$];
  int         cap_t [$];
  int         done_cnt = 0;
  int         done_t = 0;

  always @(negedge sys_clk) begin
    if (m_valid) begin
      checks++;
      if ({busy, done, pi_flag, pi_data} !== {m_busy, m_done, m_flag, m_data}) begin
        errors++;
        $display("FAIL cycle_cmp edge=%0d busy/done/flag/data got %b/%b/%b/%02h want %b/%b/%b/%02h",
                 edge_n, busy, done, pi_flag, pi_data, m_busy, m_done, m_flag, m_data);
      end
    end
    if (pi_flag === 1'b1) begin
      cap_q.push_back(pi_data);
      cap_t.push_back(edge_n);
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_t = edge_n;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge sys_clk);
    #1;
  endtask

  // start is raised right after an edge; it is sampled on the next one.
  task automatic pulse_start(output int drive_edge);
    @(posedge sys_clk); #1;
    start = 1'b1;
    drive_edge = edge_n;
    @(posedge sys_clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_strobes(input int n, input string name);
    int b;
    for (b = 0; b < 3000; b++) begin
      @(negedge sys_clk); #1;
      if (cap_q.size() >= n) break;
    end
    if (b == 3000) chk({name, "_strobe_timeout"}, cap_q.size(), n);
  endtask

  task automatic wait_done(input string name);
    int b;
    for (b = 0; b < 3000; b++) begin
      @(negedge sys_clk); #1;
      if (done === 1'b1) break;
    end
    if (b == 3000) chk({name, "_done_timeout"}, 0, 1);
  endtask

  task automatic rand_cfg();
    pulse_select = 2'($urandom_range(0, 3));
    pulse_width1 = 16'($urandom);
    pulse_width2 = 16'($urandom);
    pulse_gap    = 16'($urandom);
  endtask

  task automatic chk_frame(input string name, input logic [1:0] sel,
                           input logic [15:0] w1, input logic [15:0] w2,
                           input logic [15:0] gp);
    logic [7:0] e [9];
    e[0] = 8'h07;           e[1] = {7'b0, sel[0]}; e[2] = {7'b0, sel[1]};
    e[3] = w1[15:8];        e[4] = w1[7:0];
    e[5] = w2[15:8];        e[6] = w2[7:0];
    e[7] = gp[15:8];        e[8] = gp[7:0];
    chk({name, "_count"}, cap_q.size(), 9);
    for (int i = 0; i < 9; i++)
      chk($sformatf("%s_byte%0d", name, i), (i < cap_q.size()) ? int'(cap_q[i]) : -1, int'(e[i]));
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int s_edge, d0;
    logic [1:0]  c_sel;
    logic [15:0] c_w1, c_w2, c_gp;
    logic [7:0]  exp_a [9];
    exp_a = '{8'h07, 8'h01, 8'h00, 8'h00, 8'h08, 8'h00, 8'h05, 8'h01, 8'h00};

    sys_rst = 1'b1; start = 1'b0;
    pulse_select = 2'b00; pulse_width1 = '0; pulse_width2 = '0; pulse_gap = '0;
    cycles(3);
    sys_rst = 1'b0;
    cycles(100);
    chk("idle_pi_flag", pi_flag, 0);
    chk("idle_busy",    busy,    0);
    chk("idle_done",    done,    0);
    chk("idle_pi_data", pi_data, 0);

    // Frame A, then scramble inputs during LOAD.
    pulse_select = 2'b01; pulse_width1 = 16'h0008; pulse_width2 = 16'h0005; pulse_gap = 16'h0100;
    cap_q.delete(); cap_t.delete(); d0 = done_cnt;
    @(posedge sys_clk); #1;
    start = 1'b1; s_edge = edge_n;
    @(posedge sys_clk); #1;
    start = 1'b0;
    pulse_select = 2'b11; pulse_width1 = 16'hFFFF; pulse_width2 = 16'hFFFF; pulse_gap = 16'hFFFF;
    wait_done("frameA");
    chk("frameA_count", cap_q.size(), 9);
    for (int i = 0; i < 9; i++)
      chk($sformatf("frameA_byte%0d", i), (i < cap_q.size()) ? int'(cap_q[i]) : -1, int'(exp_a[i]));
    if (cap_q.size() == 9) begin
      chk("frameA_first_latency", cap_t[0] - s_edge, 2);
      for (int i = 0; i < 8; i++)
        chk($sformatf("frameA_spacing%0d", i), cap_t[i+1] - cap_t[i], 111);
    end
    chk("frameA_done_latency", done_t - s_edge, 1001);
    chk("frameA_done_pulses", done_cnt - d0, 1);

    // Frame B: start pulses during byte 4 and during DONE are ignored.
    rand_cfg();
    c_sel = pulse_select; c_w1 = pulse_width1; c_w2 = pulse_width2; c_gp = pulse_gap;
    cap_q.delete(); cap_t.delete(); d0 = done_cnt;
    pulse_start(s_edge);
    wait_strobes(5, "frameB");
    start = 1'b1;
    @(posedge sys_clk); #1; start = 1'b0;
    wait_done("frameB");
    start = 1'b1;
    @(posedge sys_clk); #1; start = 1'b0;
    cycles(50);
    chk_frame("frameB", c_sel, c_w1, c_w2, c_gp);
    chk("frameB_done_pulses", done_cnt - d0, 1);
    chk("frameB_busy_after", busy, 0);

    // Reset during WAIT after byte 5, together with a start.
    rand_cfg();
    cap_q.delete(); cap_t.delete();
    pulse_start(s_edge);
    wait_strobes(6, "rst_mid");
    cycles(5);
    sys_rst = 1'b1; start = 1'b1;
    @(posedge sys_clk); #1;
    sys_rst = 1'b0; start = 1'b0;
    chk("rst_mid_pi_flag", pi_flag, 0);
    chk("rst_mid_busy",    busy,    0);
    chk("rst_mid_done",    done,    0);
    chk("rst_mid_pi_data", pi_data, 0);
    cycles(200);
    chk("rst_mid_strobes", cap_q.size(), 6);
    rand_cfg();
    c_sel = pulse_select; c_w1 = pulse_width1; c_w2 = pulse_width2; c_gp = pulse_gap;
    cap_q.delete(); cap_t.delete();
    pulse_start(s_edge);
    wait_done("after_rst");
    chk_frame("after_rst", c_sel, c_w1, c_w2, c_gp);

    // Back-to-back: start in the cycle right after done.
    @(posedge sys_clk); #1;
    start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    d0 = done_t;
    cap_q.delete(); cap_t.delete();
    wait_strobes(1, "b2b");
    if (cap_t.size() > 0) chk("b2b_first_flag", cap_t[0] - d0, 3);
    wait_done("b2b");
    chk("b2b_count", cap_q.size(), 9);

    // Random start/config traffic, model checks every cycle.
    for (int i = 0; i < 8000; i++) begin
      @(posedge sys_clk); #1;
      start = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 9) == 0) rand_cfg();
    end
    start = 1'b0;
    cycles(1100);
    chk("final_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
